// File: rtl/avalon_flit_master_pkg.sv
// Shared constants and types for the Avalon flit bridge initiator.
package avalon_flit_master_pkg;

   localparam int FLIT_W = 32;

   // Slave register map
   localparam logic [2:0] ADDR_STATUS = 3'd0;
   localparam logic [2:0] ADDR_PUT    = 3'd1;
   localparam logic [2:0] ADDR_GET    = 3'd2;

   // Status word bit positions
   localparam int STAT_PUT_OK = 0;
   localparam int STAT_GET_OK = 1;

   typedef enum logic [1:0] {
      ST_POLL  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_WAIT  = 2'd3
   } state_t;

endpackage

// File: rtl/avalon_flit_master_if.sv
// Avalon-MM bus between the flit initiator and the bridge slave port.
interface avalon_flit_master_if;
   import avalon_flit_master_pkg::*;

   logic [2:0]        address;
   logic              read;
   logic [FLIT_W-1:0] readdata;
   logic              write;
   logic [FLIT_W-1:0] writedata;
   logic              irq;

   modport master (
      output address,
      output read,
      input  readdata,
      output write,
      output writedata,
      input  irq
   );

   modport slave (
      input  address,
      input  read,
      output readdata,
      input  write,
      input  writedata,
      output irq
   );

endinterface

// File: rtl/flit_fifo.sv
// Small synchronous FIFO with registered count and ready flags and a
// combinational head. A push into a full FIFO is accepted only when a pop
// happens in the same cycle; a pop from an empty FIFO is ignored.
module flit_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk_sys,
   input  logic             rst_b,
   input  logic [WIDTH-1:0] din,
   input  logic             enq,
   input  logic             deq,
   output logic [WIDTH-1:0] head,
   output logic             not_full,
   output logic             not_empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_nxt;
   logic             enq_ok;
   logic             deq_ok;

   assign deq_ok = deq & not_empty;
   assign enq_ok = enq & (not_full | deq_ok);

   // Occupancy after this cycle's push/pop
   always_comb begin
      count_nxt = count;
      case ({enq_ok, deq_ok})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   // Pointers, count and registered ready flags
   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         not_full  <= 1'b1;
         not_empty <= 1'b0;
      end else begin
         if (enq_ok) wr_ptr <= wr_ptr + 1'b1;
         if (deq_ok) rd_ptr <= rd_ptr + 1'b1;
         count     <= count_nxt;
         not_full  <= (count_nxt != DEPTH_C);
         not_empty <= (count_nxt != '0);
      end
   end

   // Storage; contents are don't-care while the slot is unoccupied
   always_ff @(posedge clk_sys) begin
      if (enq_ok) mem[wr_ptr] <= din;
   end

   // Head is forced to zero when empty so stale data never leaks out
   assign head = not_empty ? mem[rd_ptr] : '0;

endmodule

// File: rtl/avalon_flit_master.sv
// Hardware Avalon-MM initiator that moves flits between local TX/RX FIFOs
// and the flit bridge slave by polling its status word.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_POLL  | read status (addr 0), pick next transfer from put_ok/get_ok
// ST_WRITE | write TX head to put register (addr 1), pop TX
// ST_READ  | read get register (addr 2), push into RX
// ST_WAIT  | back-off countdown; early exit on irq with RX room
module avalon_flit_master
   import avalon_flit_master_pkg::*;
#(
   parameter int FIFO_DEPTH    = 4,
   parameter int POLL_INTERVAL = 8
) (
   input  logic               CLK,
   input  logic               RST_N,
   avalon_flit_master_if.master av,
   input  logic [FLIT_W-1:0]  putFlit_put,
   input  logic               EN_putFlit_put,
   output logic               RDY_putFlit_put,
   output logic [FLIT_W-1:0]  getFlit_get,
   input  logic               EN_getFlit_get,
   output logic               RDY_getFlit_get
);

   localparam logic [7:0] WAIT_LOAD = 8'(POLL_INTERVAL);

   state_t            state;
   state_t            state_nxt;
   logic              pri;
   logic              pri_nxt;
   logic [7:0]        wait_cnt;
   logic [7:0]        wait_cnt_nxt;
   logic              run;
   logic [FLIT_W-1:0] wdata_q;

   logic [FLIT_W-1:0] tx_head;
   logic              tx_not_empty;
   logic              rx_not_full;
   logic              tx_pop;
   logic              rx_push;
   logic              put_ok;
   logic              get_ok;
   logic              tx_elig;
   logic              rx_elig;

   assign tx_pop  = run & (state == ST_WRITE);
   assign rx_push = run & (state == ST_READ);

   assign put_ok  = av.readdata[STAT_PUT_OK];
   assign get_ok  = av.readdata[STAT_GET_OK];
   assign tx_elig = put_ok & tx_not_empty;
   assign rx_elig = get_ok & rx_not_full;

   flit_fifo #(
      .WIDTH (FLIT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk_sys   (CLK),
      .rst_b     (RST_N),
      .din       (putFlit_put),
      .enq       (EN_putFlit_put),
      .deq       (tx_pop),
      .head      (tx_head),
      .not_full  (RDY_putFlit_put),
      .not_empty (tx_not_empty)
   );

   flit_fifo #(
      .WIDTH (FLIT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_rx_fifo (
      .clk_sys   (CLK),
      .rst_b     (RST_N),
      .din       (av.readdata),
      .enq       (rx_push),
      .deq       (EN_getFlit_get),
      .head      (getFlit_get),
      .not_full  (rx_not_full),
      .not_empty (RDY_getFlit_get)
   );

   // State, arbitration bit, back-off counter and held write data.
   // run stays low during reset so the POLL decode cannot strobe until
   // the first edge after release.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= ST_POLL;
         pri      <= 1'b0;
         wait_cnt <= '0;
         run      <= 1'b0;
         wdata_q  <= '0;
      end else begin
         state    <= state_nxt;
         pri      <= pri_nxt;
         wait_cnt <= wait_cnt_nxt;
         run      <= 1'b1;
         if (state_nxt == ST_WRITE) wdata_q <= tx_head;
      end
   end

   // Next-state: arbitration in POLL, countdown / irq wake in WAIT
   always_comb begin
      state_nxt    = state;
      pri_nxt      = pri;
      wait_cnt_nxt = wait_cnt;
      if (run) begin
         case (state)
            ST_POLL: begin
               if (tx_elig && rx_elig) begin
                  state_nxt = pri ? ST_READ : ST_WRITE;
                  pri_nxt   = ~pri;
               end else if (tx_elig) begin
                  state_nxt = ST_WRITE;
               end else if (rx_elig) begin
                  state_nxt = ST_READ;
               end else begin
                  state_nxt    = ST_WAIT;
                  wait_cnt_nxt = WAIT_LOAD;
               end
            end
            ST_WRITE,
            ST_READ: state_nxt = ST_POLL;
            ST_WAIT: begin
               wait_cnt_nxt = (wait_cnt == 8'd0) ? 8'd0 : wait_cnt - 8'd1;
               if ((wait_cnt <= 8'd1) || (av.irq && rx_not_full)) begin
                  state_nxt = ST_POLL;
               end
            end
            default: state_nxt = ST_POLL;
         endcase
      end
   end

   // Avalon strobes decoded from the state register only
   always_comb begin
      av.read    = 1'b0;
      av.write   = 1'b0;
      av.address = ADDR_STATUS;
      if (run) begin
         case (state)
            ST_POLL: av.read = 1'b1;
            ST_WRITE: begin
               av.write   = 1'b1;
               av.address = ADDR_PUT;
            end
            ST_READ: begin
               av.read    = 1'b1;
               av.address = ADDR_GET;
            end
            default: ;
         endcase
      end
   end

   assign av.writedata = wdata_q;

endmodule

// File: tb/tb_avalon_flit_master.sv
// Directed bench for avalon_flit_master with a zero-latency slave model.
module tb_avalon_flit_master;
   import avalon_flit_master_pkg::*;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic [31:0] putFlit_put = '0;
   logic        EN_putFlit_put = 1'b0;
   logic        RDY_putFlit_put;
   logic [31:0] getFlit_get;
   logic        EN_getFlit_get = 1'b0;
   logic        RDY_getFlit_get;

   logic [31:0] status = '0;
   logic [31:0] get_base = '0;
   logic [31:0] get_cnt;

   int n_pass = 0;
   int n_total = 0;
   int overlaps = 0;

   avalon_flit_master_if av ();

   avalon_flit_master #(.FIFO_DEPTH(4), .POLL_INTERVAL(8)) dut (
      .CLK             (CLK),
      .RST_N           (RST_N),
      .av              (av.master),
      .putFlit_put     (putFlit_put),
      .EN_putFlit_put  (EN_putFlit_put),
      .RDY_putFlit_put (RDY_putFlit_put),
      .getFlit_get     (getFlit_get),
      .EN_getFlit_get  (EN_getFlit_get),
      .RDY_getFlit_get (RDY_getFlit_get)
   );

   always #5 CLK = ~CLK;

   // Slave: status at 0, incrementing get value at 2, no latency
   assign av.readdata = (av.address == 3'd0) ? status :
                        (av.address == 3'd2) ? (get_base + get_cnt) : 32'h0;

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) get_cnt <= '0;
      else if (av.read && av.address == 3'd2) get_cnt <= get_cnt + 1;
   end

   always @(negedge CLK) if (av.read && av.write) overlaps++;

   typedef struct {
      string       name;
      logic [31:0] status;
      logic        put_en;
      logic [31:0] put_data;
      logic [31:0] get_data;
      int          exp_kind;   // 0 none, 1 write, 2 get-read
      int          exp_cyc;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic apply_reset();
      RST_N = 1'b0;
      EN_putFlit_put = 1'b0;
      EN_getFlit_get = 1'b0;
      av.irq = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      int kind, cyc, np, nr, nw, drained;
      logic [31:0] data, exp_rx;
      int pc[3];
      int kinds[8];
      logic [31:0] wdat[4];
      int nk, nwr;

      vecs[0] = '{"tx",          32'h1, 1'b1, 32'hDEADBEEF, 32'h0,        1, 2, 32'hDEADBEEF};
      vecs[1] = '{"rx",          32'h2, 1'b0, 32'h0,        32'h12345678, 2, 2, 32'h12345678};
      vecs[2] = '{"both_pri0",   32'h3, 1'b1, 32'hA5A55A5A, 32'h0BADF00D, 1, 2, 32'hA5A55A5A};
      vecs[3] = '{"putok_empty", 32'h1, 1'b0, 32'h0,        32'h0,        0, 0, 32'h0};
      vecs[4] = '{"rx_no_putok", 32'h2, 1'b1, 32'h77777777, 32'h89ABCDEF, 2, 2, 32'h89ABCDEF};
      vecs[5] = '{"idle",        32'h0, 1'b1, 32'h31415926, 32'h0,        0, 0, 32'h0};
      vecs[6] = '{"getok_only",  32'h3, 1'b0, 32'h0,        32'hFEEDFACE, 2, 2, 32'hFEEDFACE};

      // Reset values
      av.irq = 1'b0;
      tick();
      tick();
      check("rst_read", av.read, 0);
      check("rst_write", av.write, 0);
      check("rst_address", av.address, 0);
      check("rst_writedata", av.writedata, 0);
      check("rst_rdy_put", RDY_putFlit_put, 1);
      check("rst_rdy_get", RDY_getFlit_get, 0);
      check("rst_getflit", getFlit_get, 0);
      RST_N = 1'b1;
      tick();
      check("first_poll_read", av.read, 1);
      check("first_poll_addr", av.address, 0);

      // Table-driven single transfers from a clean reset
      for (int v = 0; v < 7; v++) begin
         apply_reset();
         status = vecs[v].status;
         get_base = vecs[v].get_data;
         putFlit_put = vecs[v].put_data;
         EN_putFlit_put = vecs[v].put_en;
         RST_N = 1'b1;
         kind = 0; cyc = 0; data = '0;
         for (int c = 1; c <= 12 && kind == 0; c++) begin
            tick();
            EN_putFlit_put = 1'b0;
            if (av.write) begin
               kind = 1; cyc = c; data = av.writedata;
               if (av.address != 3'd1) $display("FAIL %s_wr_addr: got %0d expected 1", vecs[v].name, av.address);
            end else if (av.read && av.address == 3'd2) begin
               kind = 2; cyc = c; data = av.readdata;
            end
         end
         check({vecs[v].name, "_kind"}, kind, vecs[v].exp_kind);
         if (vecs[v].exp_kind != 0) begin
            check({vecs[v].name, "_cycle"}, cyc, vecs[v].exp_cyc);
            check({vecs[v].name, "_data"}, data, vecs[v].exp_data);
            tick();
            if (vecs[v].exp_kind == 1) begin
               check({vecs[v].name, "_wr_1cycle"}, av.write, 0);
            end else begin
               check({vecs[v].name, "_rdy_get"}, RDY_getFlit_get, 1);
               check({vecs[v].name, "_getflit"}, getFlit_get, vecs[v].exp_data);
            end
         end
      end

      // Arbitration: TX pre-filled with 4, status=3, RX drained
      apply_reset();
      status = 32'h0;
      get_base = 32'h1000_0000;
      RST_N = 1'b1;
      for (int k = 0; k < 4; k++) begin
         EN_putFlit_put = 1'b1;
         putFlit_put = 32'hA0 + k;
         tick();
      end
      EN_putFlit_put = 1'b0;
      status = 32'h3;
      nk = 0; nwr = 0; drained = 0; exp_rx = 32'h1000_0000;
      for (int c = 0; c < 60 && nk < 8; c++) begin
         tick();
         if (RDY_getFlit_get) begin
            check("arb_rx_order", getFlit_get, exp_rx);
            exp_rx++;
            drained++;
            EN_getFlit_get = 1'b1;
         end else begin
            EN_getFlit_get = 1'b0;
         end
         if (av.write) begin
            kinds[nk] = 1; nk++;
            if (nwr < 4) wdat[nwr] = av.writedata;
            nwr++;
         end else if (av.read && av.address == 3'd2) begin
            kinds[nk] = 2; nk++;
         end
      end
      EN_getFlit_get = 1'b0;
      check("arb_count", nk, 8);
      for (int k = 0; k < 8; k++) check($sformatf("arb_kind%0d", k), kinds[k], (k % 2 == 0) ? 1 : 2);
      for (int k = 0; k < 4; k++) check($sformatf("arb_wdata%0d", k), wdat[k], 32'hA0 + k);
      check("arb_drained", drained, 3);

      // Poll spacing with TX pending but put_ok=0, then irq wake
      apply_reset();
      status = 32'h0;
      RST_N = 1'b1;
      EN_putFlit_put = 1'b1;
      putFlit_put = 32'hCAFE0001;
      np = 0;
      for (int c = 1; c <= 40 && np < 3; c++) begin
         tick();
         EN_putFlit_put = 1'b0;
         if (av.read && av.address == 3'd0) begin
            pc[np] = c;
            np++;
         end
      end
      check("poll_count", np, 3);
      check("poll_first", pc[0], 1);
      check("poll_gap1", pc[1] - pc[0], 9);
      check("poll_gap2", pc[2] - pc[1], 9);
      tick();
      tick();
      tick();
      check("wait_no_strobe", av.read | av.write, 0);
      av.irq = 1'b1;
      tick();
      check("irq_wake_poll", av.read && av.address == 3'd0, 1);
      av.irq = 1'b0;
      tick();
      check("post_irq_wait", av.read, 0);

      // RX back-pressure: no get-read once RX holds 4, even with irq
      apply_reset();
      status = 32'h2;
      get_base = 32'h5500_0000;
      av.irq = 1'b1;
      RST_N = 1'b1;
      nr = 0;
      for (int c = 0; c < 50; c++) begin
         tick();
         if (av.read && av.address == 3'd2) nr++;
      end
      av.irq = 1'b0;
      check("full_read_count", nr, 4);
      check("full_rdy_get", RDY_getFlit_get, 1);
      check("full_head", getFlit_get, 32'h5500_0000);

      // Reset during WRITE drops the strobe and flushes the FIFOs
      apply_reset();
      status = 32'h1;
      RST_N = 1'b1;
      EN_putFlit_put = 1'b1;
      putFlit_put = 32'h11111111;
      tick();
      putFlit_put = 32'h22222222;
      tick();
      EN_putFlit_put = 1'b0;
      check("midrst_write_on", av.write, 1);
      check("midrst_wdata", av.writedata, 32'h11111111);
      #2 RST_N = 1'b0;
      #1;
      check("midrst_write_drop", av.write, 0);
      check("midrst_read_low", av.read, 0);
      tick();
      RST_N = 1'b1;
      EN_getFlit_get = 1'b1;
      tick();
      EN_getFlit_get = 1'b0;
      nw = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (av.write) nw++;
      end
      check("midrst_tx_flushed", nw, 0);
      check("midrst_rdy_get", RDY_getFlit_get, 0);
      check("midrst_rdy_put", RDY_putFlit_put, 1);

      check("strobe_overlap", overlaps, 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/avalon_flit_master.md
# avalon_flit_master

Hardware Avalon-MM initiator for the inter-FPGA flit bridge's Nios-facing slave port. It replaces the Nios polling loop in echo/loopback builds and in DMA-less test images. It polls the slave's status word, writes outbound flits to the put register, and reads inbound flits from the get register. A local get/put flit interface with small internal FIFOs feeds it.

## Interface
Parameters:
- FIFO_DEPTH, 4: entries in each of the TX and RX FIFOs; power of two, at least 2.
- POLL_INTERVAL, 8: idle cycles between status polls when no transfer is eligible; range 0..255.

Ports:
- CLK  input  1  single clock for the whole block.
- RST_N  input  1  reset, asynchronous and active-low.
- address  output  3  Avalon address; 0 = status, 1 = put, 2 = get.
- read  output  1  Avalon read strobe.
- readdata  input  32  Avalon read data; slave has zero read latency and no waitrequest.
- write  output  1  Avalon write strobe.
- writedata  output  32  Avalon write data.
- irq  input  1  slave "inbound flit available" level.
- putFlit_put  input  32  outbound flit from local logic.
- EN_putFlit_put  input  1  enqueue strobe; legal only while RDY_putFlit_put is high.
- RDY_putFlit_put  output  1  TX FIFO not full.
- getFlit_get  output  32  head of RX FIFO.
- EN_getFlit_get  input  1  dequeue strobe; legal only while RDY_getFlit_get is high.
- RDY_getFlit_get  output  1  RX FIFO not empty.

## Operation
- States: POLL, WRITE, READ, WAIT.
- POLL drives read=1, address=0, and samples readdata at the end of the cycle. Status bit0 = put_ok. Status bit1 = get_ok.
- Eligibility, evaluated in POLL:
  - tx_elig = put_ok and TX FIFO non-empty.
  - rx_elig = get_ok and RX FIFO not full.
- POLL next state:
  - Only tx_elig → WRITE.
  - Only rx_elig → READ.
  - Both → the one selected by the priority bit `pri` (0 = WRITE), then toggle `pri`.
  - Neither → WAIT, load wait counter with POLL_INTERVAL.
- WRITE drives write=1, address=1, writedata=TX head. The TX head pops at the end of the cycle. Next state is POLL.
- READ drives read=1, address=2. readdata is pushed into the RX FIFO at the end of the cycle. Next state is POLL.
- WAIT decrements the counter. It goes to POLL when the counter reaches 0, or immediately when irq=1 and the RX FIFO is not full.
- Outputs are decodes of the state register and the TX FIFO head only. There is no combinational path from readdata or irq to any Avalon output. In WAIT all strobes are 0, address=0, and writedata holds its last value.
- At most one strobe is high in any cycle. Every strobe lasts exactly one cycle.

## Timing
- Reset (async assert) values:
  - State = POLL, pri = 0, both FIFOs empty, wait counter 0.
  - read = write = 0, address = 0, writedata = 0.
  - RDY_putFlit_put = 1, RDY_getFlit_get = 0, getFlit_get = 0.
- Reset exit: the first POLL strobe appears in the first clock edge after RST_N deasserts. Strobes are forced low while RST_N = 0.
- Reset mid-transfer drops the strobe asynchronously. All buffered flits are discarded.
- Latency, both directions:
  - TX: a flit enqueued at edge n can appear on writedata with write=1 at the earliest in cycle n+2 (POLL in n+1).
  - RX: readdata captured in READ at edge m gives RDY_getFlit_get=1 from m+1.
- Steady-state throughput is one flit per 2 cycles. With both directions saturated, the pattern is W,R,W,R.
- FIFO boundaries:
  - Simultaneous enq and internal deq are allowed in every occupancy state, including full (TX) and empty→1 (RX).
  - Count is unchanged when both happen.
  - Pointers wrap modulo FIFO_DEPTH.
- RX full: READ is never issued, even with get_ok=1 or irq=1.
- Put while not ready, or get while empty, is illegal. The FIFO must ignore it and keep its state unchanged.

## Structure
- Shared package holds:
  - Address constants ADDR_STATUS=0, ADDR_PUT=1, ADDR_GET=2.
  - Status bit indices STAT_PUT_OK=0, STAT_GET_OK=1.
  - Flit width 32.
  - The state enum.
- Sub-module flit_fifo (parameters WIDTH, DEPTH) is instantiated twice, for TX and RX. It uses registered count and registered ready flags, and shows the head combinationally.

## Test plan
- Reset: hold RST_N=0 → all Avalon outputs 0, RDY_putFlit_put=1, RDY_getFlit_get=0. Release → POLL read at address 0 on the next cycle.
- TX path: slave status=0x1, put 0xDEADBEEF → one POLL, then a single-cycle write at address 1 with writedata=0xDEADBEEF. TX FIFO is empty afterwards.
- RX path: slave status=0x2, get register=0x12345678 → read at address 2. The cycle after, RDY_getFlit_get=1 and getFlit_get=0x12345678.
- Arbitration: status=0x3 held, TX pre-filled with 4 flits, RX drained continuously → transfers alternate W,R,W,R and flit order is preserved.
- Idle and irq:
  - Status=0x0 with TX pending → polls spaced POLL_INTERVAL+1 cycles apart (9 at default).
  - irq raised in WAIT → POLL on the next cycle.
- Back-pressure and reset:
  - RX filled to 4, status=0x2 → no address-2 read is issued.
  - RST_N dropped during WRITE → write falls in the same cycle and the FIFOs are empty after release.
